// File: rtl/main_fsm.sv
// Multicycle processor main control FSM: Moore machine, outputs decoded from the state register.
// Define COND_SKIP_EN to send failed-condition instructions straight from DECODE back to FETCH.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q, state_d;
  state_t decode_tgt;

  logic unused_bits;
  assign unused_bits = ^{Funct[4:1], CondEx};

  always_comb begin
    decode_tgt = S_FETCH;
    case (Op)
      2'b00:   decode_tgt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
      2'b01:   decode_tgt = S_MEMADR;
      2'b10:   decode_tgt = S_BRANCH;
      default: decode_tgt = S_FETCH;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
`ifdef COND_SKIP_EN
        state_d = CondEx ? decode_tgt : S_FETCH;
`else
        state_d = decode_tgt;
`endif
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;  // also recovers from the unused encodings 10-15
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUOp   = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_ALUWB:    RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: instruction-level reference model producing expected state traces.
// Honors COND_SKIP_EN the same way as the design build.
module tb_main_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       CondEx;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;
  logic [12:0] obs;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .CondEx(CondEx),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .State(State)
  );

  assign obs = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, ALUSrcA, ALUSrcB, ResultSrc};

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int n_rst = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {IRWrite,AdrSrc,NextPC,RegW,MemW,Branch,ALUOp,ALUSrcA,ALUSrcB,ResultSrc}
  function automatic logic [12:0] exp_out(input int s);
    case (s)
      0: return 13'b1010000_01_10_10;
      1: return 13'b0000000_01_10_10;
      2: return 13'b0000000_00_01_00;
      3: return 13'b0100000_00_00_00;
      4: return 13'b0001000_00_00_01;
      5: return 13'b0100100_00_00_00;
      6: return 13'b0000001_00_00_00;
      7: return 13'b0000001_00_01_00;
      8: return 13'b0001000_00_00_00;
      9: return 13'b0000010_10_01_10;
      default: return 13'b0;
    endcase
  endfunction

  task automatic build_seq(input logic [1:0] op, input logic [5:0] fn, input logic ce);
    bit skip;
    skip = 1'b0;
`ifdef COND_SKIP_EN
    skip = !ce;
`endif
    exp_q = {0, 1};
    if (!skip) begin
      case (op)
        2'b01: if (fn[0]) exp_q = {exp_q, 2, 3, 4}; else exp_q = {exp_q, 2, 5};
        2'b00: if (fn[5]) exp_q = {exp_q, 7, 8};    else exp_q = {exp_q, 6, 8};
        2'b10: exp_q.push_back(9);
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [1:0] iop;
    logic [5:0] ifn;
    logic       ice;
    int         cur;
    bit         rst;
    iop = 2'b00; ifn = 6'd0; ice = 1'b1;
    reset = 1'b1; Op = 2'b11; Funct = 6'h3f; CondEx = 1'b1;

    // reset held for several edges: FETCH with FETCH outputs throughout
    repeat (3) begin
      @(negedge clk);
      chk("hold_state", 16'(State), 16'd0);
      chk("hold_outs", 16'(obs), 16'(exp_out(0)));
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_edge_state", 16'(State), 16'd1);
    reset = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0) begin
        iop = 2'($urandom_range(0, 3));
        ifn = 6'($urandom);
        ice = ($urandom_range(0, 3) != 0);
        build_seq(iop, ifn, ice);
      end
      cur = exp_q[0];
      @(negedge clk);
      chk("state", 16'(State), 16'(cur));
      chk("outs", 16'(obs), 16'(exp_out(cur)));
      if (cur == 1) begin
        Op = iop; Funct = ifn; CondEx = ice;
      end else if (cur == 2) begin
        Op = 2'($urandom); Funct = ifn; CondEx = 1'($urandom);
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom); CondEx = 1'($urandom);
      end
      rst = ($urandom_range(0, 39) == 0) ||
            ((cur == 5 || cur == 8) && $urandom_range(0, 3) == 0);
      reset = rst;
      @(posedge clk);
      if (rst) begin
        n_rst++;
        exp_q.delete();
      end else begin
        void'(exp_q.pop_front());
      end
    end
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
